// File: rtl/st7735s_spi_tx.sv
// Drains the ST7735s init command ROM over SPI mode 0 with D/C and CS,
// inserting the panel's mandatory waits after SWRESET and SLPOUT.
module st7735s_spi_tx #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned RST_WAIT = 6_000_000,
   parameter int unsigned SLP_WAIT = 6_000_000,
   parameter int unsigned SETTLE   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [8:0] cmd_word,
   input  logic       cmd_finished,
   output logic       resend,
   output logic       advance,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_dc,
   output logic       spi_cs_n,
   output logic       busy,
   output logic       init_done
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
   localparam int unsigned SET_W = $clog2(SETTLE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
   localparam logic [31:0]      RST_W    = 32'(RST_WAIT);
   localparam logic [31:0]      SLP_W    = 32'(SLP_WAIT);

   typedef enum logic [3:0] {
      S_IDLE, S_RESEND, S_SETTLE, S_LOAD, S_SHIFT, S_END, S_WAIT, S_ADV, S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [8:0]       word_q, word_d;
   logic [31:0]      wait_q, wait_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             dc_q, dc_d;
   logic             cs_n_q, cs_n_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         word_q   <= '0;
         wait_q   <= '0;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         dc_q     <= 1'b0;
         cs_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         word_q   <= word_d;
         wait_q   <= wait_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         dc_q     <= dc_d;
         cs_n_q   <= cs_n_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      word_d   = word_q;
      wait_d   = wait_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      dc_d     = dc_q;
      cs_n_d   = cs_n_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_RESEND;
         S_RESEND, S_ADV: begin
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SET_LAST) state_d = S_LOAD;
            else                      settle_d = settle_q + 1'b1;
         end
         S_LOAD: begin
            if (cmd_word == 9'h000 || cmd_finished) begin
               state_d = S_DONE;
            end else begin
               word_d  = cmd_word;
               shreg_d = cmd_word[7:0];
               dc_d    = cmd_word[8];
               mosi_d  = cmd_word[7];
               cs_n_d  = 1'b0;
               sck_d   = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
            end
         end
         // Each half-period lasts CLK_DIV cycles; mosi moves only with the falling edge.
         S_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     cs_n_d  = 1'b1;
                     mosi_d  = 1'b0;
                     state_d = S_END;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     shreg_d = {shreg_q[6:0], 1'b0};
                     mosi_d  = shreg_q[6];
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_END: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (word_q == 9'h001 && RST_W != '0) begin
                  wait_d  = RST_W;
                  state_d = S_WAIT;
               end else if (word_q == 9'h011 && SLP_W != '0) begin
                  wait_d  = SLP_W;
                  state_d = S_WAIT;
               end else begin
                  state_d = S_ADV;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (wait_q <= 32'd1) state_d = S_ADV;
            else                 wait_d  = wait_q - 32'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      resend    = 1'b0;
      advance   = 1'b0;
      busy      = 1'b1;
      init_done = 1'b0;
      case (state_q)
         S_IDLE:   busy = 1'b0;
         S_DONE: begin
            busy      = 1'b0;
            init_done = 1'b1;
         end
         S_RESEND: resend  = 1'b1;
         S_ADV:    advance = 1'b1;
         default:  ;
      endcase
   end

   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;
   assign spi_dc   = dc_q;
   assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_st7735s_spi_tx.sv
// Directed bench for st7735s_spi_tx: ROM model, bus decoder and table of expected bytes/gaps.
module tb_st7735s_spi_tx;

   localparam int CLK_DIV  = 2;
   localparam int RST_WAIT = 50;
   localparam int SLP_WAIT = 80;
   localparam int SETTLE   = 3;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [8:0] cmd_word = '0;
   logic       cmd_finished = 1'b1;
   logic       resend, advance, spi_sck, spi_mosi, spi_dc, spi_cs_n, busy, init_done;

   st7735s_spi_tx #(
      .CLK_DIV (CLK_DIV),
      .RST_WAIT(RST_WAIT),
      .SLP_WAIT(SLP_WAIT),
      .SETTLE  (SETTLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cmd_word    (cmd_word),
      .cmd_finished(cmd_finished),
      .resend      (resend),
      .advance     (advance),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_dc      (spi_dc),
      .spi_cs_n    (spi_cs_n),
      .busy        (busy),
      .init_done   (init_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM model: registered read, one cycle behind the address.
   logic [8:0] rom [0:7];
   logic [3:0] addr = '0;
   always @(posedge clk) begin
      if (resend)       addr <= '0;
      else if (advance) addr <= addr + 4'd1;
      cmd_word     <= (addr < 4'd8) ? rom[addr[2:0]] : 9'h000;
      cmd_finished <= (addr < 4'd8) ? (rom[addr[2:0]] == 9'h000) : 1'b1;
   end

   // Bus decoder, sampled on the falling clock edge.
   logic [8:0] words[$];
   int         nbits[$];
   int         falls[$];
   int         rises[$];
   int         adv_cnt = 0, res_cnt = 0, viol = 0;
   int         last_adv = -1000, last_rise = -1, bitn = 0;
   logic [7:0] sh = '0;
   logic       cur_dc = 1'b0;
   logic       p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_adv = 1'b0;

   always @(negedge clk) begin
      if (advance) begin
         adv_cnt++;
         if (p_adv) viol++;
         else if (cyc - last_adv < SETTLE + 1) viol++;
         last_adv = cyc;
      end
      if (resend) res_cnt++;
      if (p_cs && !spi_cs_n) begin
         falls.push_back(cyc);
         bitn = 0; sh = '0; cur_dc = spi_dc; last_rise = -1;
      end
      if (!spi_cs_n) begin
         if (spi_dc != cur_dc) viol++;
         if (!p_sck && spi_sck) begin
            sh = {sh[6:0], spi_mosi};
            bitn++;
            if (last_rise >= 0 && cyc - last_rise != 2 * CLK_DIV) viol++;
            last_rise = cyc;
         end
         if (p_sck && spi_sck && spi_mosi != p_mosi) viol++;
      end
      if (!p_cs && spi_cs_n) begin
         rises.push_back(cyc);
         words.push_back({cur_dc, sh});
         nbits.push_back(bitn);
      end
      p_cs = spi_cs_n; p_sck = spi_sck; p_mosi = spi_mosi; p_adv = advance;
   end

   typedef struct {
      logic [8:0] word;
      int         gap_lo;
      int         gap_hi;
   } vec_t;
   vec_t tbl[9];

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 1;
      while (!init_done && n < max) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_cs_low(input int max);
      int n = 0;
      while (spi_cs_n && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cs_fall_timeout", {31'd0, spi_cs_n}, 32'd0);
   endtask

   task automatic check_bytes(input string tag, input int b, input int first, input int cnt);
      chk({tag, "_nbytes"}, words.size() - b, cnt);
      for (int i = 0; i < cnt; i++) begin
         if (b + i < words.size()) begin
            chk($sformatf("%s_word%0d", tag, i), {23'd0, words[b + i]}, {23'd0, tbl[first + i].word});
            chk($sformatf("%s_bits%0d", tag, i), nbits[b + i], 8);
            if (tbl[first + i].gap_hi >= 0 && b + i + 1 < falls.size())
               chk_rng($sformatf("%s_gap%0d", tag, i), falls[b + i + 1] - rises[b + i],
                       tbl[first + i].gap_lo, tbl[first + i].gap_hi);
         end
      end
   endtask

   initial begin
      int b, a0, r0, n;
      tbl[0] = '{9'h001, RST_WAIT + CLK_DIV + SETTLE, 1000};
      tbl[1] = '{9'h011, SLP_WAIT, 1000};
      tbl[2] = '{9'h0B1, 0, 19};
      tbl[3] = '{9'h100, 0, 19};
      tbl[4] = '{9'h13F, 0, 19};
      tbl[5] = '{9'h02C, 0, -1};
      tbl[6] = '{9'h101, 0, 19};
      tbl[7] = '{9'h111, 0, 19};
      tbl[8] = '{9'h0A5, 0, -1};

      rst_n = 1'b0; start = 1'b0;
      for (int i = 0; i < 8; i++) rom[i] = (i < 6) ? tbl[i].word : 9'h000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {24'd0, resend, advance, spi_sck, spi_mosi, spi_dc, spi_cs_n, busy, init_done},
          32'h04);
      @(negedge clk) rst_n = 1'b1;

      // Full init sequence with a start pulse that must be ignored mid-byte.
      b = words.size(); a0 = adv_cnt; r0 = res_cnt;
      pulse_start();
      wait_cs_low(100);
      repeat (10) @(posedge clk);
      pulse_start();
      wait_done(5000, n);
      chk("run1_done", {31'd0, init_done}, 32'd1);
      chk("run1_busy", {31'd0, busy}, 32'd0);
      check_bytes("run1", b, 0, 6);
      chk("run1_advances", adv_cnt - a0, 6);
      chk("run1_resends", res_cnt - r0, 1);

      // Data bytes never wait; A5 checks bit order.
      for (int i = 0; i < 8; i++) rom[i] = (i < 3) ? tbl[6 + i].word : 9'h000;
      b = words.size();
      pulse_start();
      chk("restart_resend_done", {30'd0, resend, init_done}, 32'h2);
      wait_done(5000, n);
      chk("run2_done", {31'd0, init_done}, 32'd1);
      check_bytes("run2", b, 6, 3);

      // Empty ROM goes straight to DONE.
      for (int i = 0; i < 8; i++) rom[i] = 9'h000;
      b = falls.size(); a0 = adv_cnt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(50, n);
      chk_rng("empty_latency", n, 1, SETTLE + 3);
      chk("empty_done", {31'd0, init_done}, 32'd1);
      chk("empty_falls", falls.size() - b, 0);
      chk("empty_advances", adv_cnt - a0, 0);

      // Asynchronous abort in the middle of bit 4, then a full replay.
      for (int i = 0; i < 8; i++) rom[i] = (i < 6) ? tbl[i].word : 9'h000;
      pulse_start();
      wait_cs_low(100);
      repeat (17) @(negedge clk);
      chk("abort_in_byte", {31'd0, spi_cs_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_bus_idle", {29'd0, spi_cs_n, spi_sck, busy}, 32'h4);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      b = words.size(); a0 = adv_cnt; r0 = res_cnt;
      pulse_start();
      wait_done(5000, n);
      chk("replay_done", {31'd0, init_done}, 32'd1);
      check_bytes("replay", b, 0, 6);
      chk("replay_advances", adv_cnt - a0, 6);
      chk("replay_resends", res_cnt - r0, 1);

      chk("protocol_violations", viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
